spi_master_reader: RTL and testbench

Single-clock SPI master that performs one read transaction against the register-RAM SPI slave: it sends an 8-bit read command carrying a 6-bit RAM address, waits a fixed turnaround gap, then clocks in 24 data bits. It sits on the controller side of the link, between local control logic (start/address in, data/done out) and the four SPI pins. SCLK is generated by dividing the system clock; the block is SPI mode 0, MSB-first.

---
 rtl/spi_master_reader_if.sv | 28 ++
 rtl/spi_master_reader.sv | 154 +++++++++++++++
 tb/tb_spi_master_reader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_reader_if.sv
// Control and SPI pin bundle for the SPI read master.
// The master modport is the controller's view; slave is the opposite side
// (local control logic driving start/rd_addr plus the SPI slave driving MISO).
interface spi_master_reader_if #(
    parameter int ADDR_SIZE = 6,
    parameter int DATA_SIZE = 24
);
    logic                 start;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 busy;
    logic                 done;
    logic [DATA_SIZE-1:0] rd_data;
    logic                 last_addr_flag;
    logic                 spi_clk;
    logic                 spi_mosi;
    logic                 spi_miso;
    logic                 spi_cs;

    modport master (
        input  start, rd_addr, spi_miso,
        output busy, done, rd_data, last_addr_flag, spi_clk, spi_mosi, spi_cs
    );

    modport slave (
        output start, rd_addr, spi_miso,
        input  busy, done, rd_data, last_addr_flag, spi_clk, spi_mosi, spi_cs
    );
endinterface

// File: rtl/spi_master_reader.sv
// SPI mode-0 read master: sends {1,0,addr} MSB first, waits a turnaround
// gap, clocks in DATA_SIZE bits and returns them little-endian by byte.
// All SPI pins are registered so an async reset forces them idle at once.
module spi_master_reader #(
    parameter int CLK_DIV   = 4,
    parameter int ADDR_SIZE = 6,
    parameter int DATA_SIZE = 24,
    parameter int CS_SETUP  = 2,
    parameter int GAP_CLKS  = 8,
    parameter int CS_HOLD   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    spi_master_reader_if.master   bus
);

    localparam int BW   = $clog2(DATA_SIZE) + 1;
    localparam int M1   = (CLK_DIV  > CS_SETUP) ? CLK_DIV  : CS_SETUP;
    localparam int M2   = (GAP_CLKS > CS_HOLD)  ? GAP_CLKS : CS_HOLD;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int NB   = DATA_SIZE / 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [7:0]           cmd_byte;
    logic [7:0]           cmd_sr;
    logic [DATA_SIZE-1:0] rx_sr;
    logic [DATA_SIZE-1:0] rx_swapped;
    logic                 half_tick;

    assign cmd_byte  = {2'b10, 6'(addr_q)};
    assign half_tick = (cnt == CW'(CLK_DIV - 1));

    // First received byte lands in the low byte of rd_data.
    always_comb begin
        rx_swapped = '0;
        for (int i = 0; i < NB; i++)
            rx_swapped[8*i +: 8] = rx_sr[DATA_SIZE-8-8*i +: 8];
    end

    // Frame sequencer: drives SCLK/CS/MOSI, shifts MISO, reports the result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= S_IDLE;
            cnt                <= '0;
            bit_cnt            <= '0;
            addr_q             <= '0;
            cmd_sr             <= '0;
            rx_sr              <= '0;
            bus.spi_cs         <= 1'b1;
            bus.spi_clk        <= 1'b0;
            bus.spi_mosi       <= 1'b0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.rd_data        <= '0;
            bus.last_addr_flag <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        addr_q             <= bus.rd_addr;
                        bus.last_addr_flag <= 1'b0;
                        bus.spi_cs         <= 1'b0;
                        bus.busy           <= 1'b1;
                        cnt                <= '0;
                        bit_cnt            <= '0;
                        state              <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == CW'(CS_SETUP - 1)) begin
                        cnt          <= '0;
                        bus.spi_mosi <= cmd_byte[7];
                        cmd_sr       <= {cmd_byte[6:0], 1'b0};
                        state        <= S_CMD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_CMD: begin
                    if (half_tick) begin
                        cnt         <= '0;
                        bus.spi_clk <= ~bus.spi_clk;
                        // MOSI only moves on the falling SCLK edge
                        if (bus.spi_clk) begin
                            if (bit_cnt == BW'(7)) begin
                                bit_cnt      <= '0;
                                bus.spi_mosi <= 1'b0;
                                state        <= S_GAP;
                            end else begin
                                bit_cnt      <= bit_cnt + BW'(1);
                                bus.spi_mosi <= cmd_sr[7];
                                cmd_sr       <= {cmd_sr[6:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == CW'(GAP_CLKS - 1)) begin
                        cnt   <= '0;
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (half_tick) begin
                        cnt         <= '0;
                        bus.spi_clk <= ~bus.spi_clk;
                        // sample on the edge that raises SCLK
                        if (!bus.spi_clk) begin
                            rx_sr <= {rx_sr[DATA_SIZE-2:0], bus.spi_miso};
                        end else if (bit_cnt == BW'(DATA_SIZE - 1)) begin
                            bit_cnt <= '0;
                            state   <= S_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == CW'(CS_HOLD - 1)) begin
                        cnt                <= '0;
                        bus.spi_cs         <= 1'b1;
                        bus.busy           <= 1'b0;
                        bus.done           <= 1'b1;
                        bus.rd_data        <= rx_swapped;
                        bus.last_addr_flag <= (addr_q == {ADDR_SIZE{1'b1}});
                        state              <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_reader.sv
// Directed bench for spi_master_reader: a default-parameter instance (a) and
// a fast instance (b, CLK_DIV=1, GAP_CLKS=1), each with a behavioural slave.
module tb_spi_master_reader;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    spi_master_reader_if #(.ADDR_SIZE(6), .DATA_SIZE(24)) ifa ();
    spi_master_reader_if #(.ADDR_SIZE(6), .DATA_SIZE(24)) ifb ();

    spi_master_reader #(.CLK_DIV(4), .ADDR_SIZE(6), .DATA_SIZE(24),
                        .CS_SETUP(2), .GAP_CLKS(8), .CS_HOLD(2))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa.master));

    spi_master_reader #(.CLK_DIV(1), .ADDR_SIZE(6), .DATA_SIZE(24),
                        .CS_SETUP(2), .GAP_CLKS(1), .CS_HOLD(2))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb.master));

    logic [1:0] sclk_v, cs_v, mosi_v, done_v, miso_r;
    assign sclk_v = {ifb.spi_clk, ifa.spi_clk};
    assign cs_v   = {ifb.spi_cs, ifa.spi_cs};
    assign mosi_v = {ifb.spi_mosi, ifa.spi_mosi};
    assign done_v = {ifb.done, ifa.done};
    assign ifa.spi_miso = miso_r[0];
    assign ifb.spi_miso = miso_r[1];

    int total = 0;
    int bad   = 0;
    int ncyc;
    logic [7:0]  mosi_byte [2];
    logic [23:0] tx_sr [2];
    logic [23:0] slave_data [2];
    int rise_cnt [2], fall_cnt [2], done_cnt [2], done_at [2];
    int first_rise_at [2], cs_fall_at [2], cs_fall_cnt [2];
    logic prev_sclk [2], prev_cs [2];

    // Slave model and event recorder, sampled on the falling clk edge.
    initial begin
        ncyc = 0;
        miso_r = 2'b00;
        for (int i = 0; i < 2; i++) begin
            mosi_byte[i] = 8'h00; tx_sr[i] = '0; slave_data[i] = '0;
            rise_cnt[i] = 0; fall_cnt[i] = 0; done_cnt[i] = 0; done_at[i] = 0;
            first_rise_at[i] = 0; cs_fall_at[i] = 0; cs_fall_cnt[i] = 0;
            prev_sclk[i] = 1'b0; prev_cs[i] = 1'b1;
        end
        forever begin
            @(negedge clk);
            ncyc++;
            for (int i = 0; i < 2; i++) begin
                if (prev_cs[i] && !cs_v[i]) begin
                    rise_cnt[i] = 0; fall_cnt[i] = 0;
                    cs_fall_at[i] = ncyc; cs_fall_cnt[i]++;
                end
                if (!prev_sclk[i] && sclk_v[i]) begin
                    if (rise_cnt[i] < 8) mosi_byte[i] = {mosi_byte[i][6:0], mosi_v[i]};
                    if (rise_cnt[i] == 0) first_rise_at[i] = ncyc;
                    rise_cnt[i]++;
                end
                if (prev_sclk[i] && !sclk_v[i]) begin
                    fall_cnt[i]++;
                    if (fall_cnt[i] == 8) tx_sr[i] = slave_data[i];
                    else if (fall_cnt[i] > 8) tx_sr[i] = tx_sr[i] << 1;
                    if (fall_cnt[i] >= 8) miso_r[i] = tx_sr[i][23];
                end
                if (done_v[i] === 1'b1) begin
                    done_cnt[i]++; done_at[i] = ncyc;
                end
                prev_sclk[i] = sclk_v[i];
                prev_cs[i]   = cs_v[i];
            end
        end
    end

    task automatic drive_start(input int i, input logic st, input logic [5:0] addr);
        if (i == 0) begin ifa.start = st; ifa.rd_addr = addr; end
        else        begin ifb.start = st; ifb.rd_addr = addr; end
    endtask

    // Raise start for one cycle (or leave it high); s = cycle before acceptance.
    task automatic start_frame(input int i, input logic [5:0] addr, input logic [23:0] data,
                               input bit hold, output int s);
        @(negedge clk); #1;
        slave_data[i] = data;
        drive_start(i, 1'b1, addr);
        s = ncyc;
        @(negedge clk); #1;
        if (!hold) drive_start(i, 1'b0, addr);
    endtask

    task automatic wait_done(input int i, input int base, input int limit);
        for (int k = 0; k < limit && done_cnt[i] == base; k++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive_start(0, 1'b0, 6'h00);
        drive_start(1, 1'b0, 6'h00);
        repeat (3) @(negedge clk);
        #1;
        total++; if (ifa.spi_cs !== 1'b1) begin bad++; $display("FAIL rst_cs: got %b want 1", ifa.spi_cs); end
        total++; if (ifa.spi_clk !== 1'b0) begin bad++; $display("FAIL rst_sclk: got %b want 0", ifa.spi_clk); end
        total++; if (ifa.spi_mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi: got %b want 0", ifa.spi_mosi); end
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", ifa.busy); end
        total++; if (ifa.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", ifa.done); end
        total++; if (ifa.rd_data !== 24'h0) begin bad++; $display("FAIL rst_data: got %h want 000000", ifa.rd_data); end
        total++; if (ifa.last_addr_flag !== 1'b0) begin bad++; $display("FAIL rst_flag: got %b want 0", ifa.last_addr_flag); end
        total++; if (ifb.spi_cs !== 1'b1) begin bad++; $display("FAIL rst_cs_b: got %b want 1", ifb.spi_cs); end
        @(negedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_read;
        int s, b;
        b = done_cnt[0];
        start_frame(0, 6'h05, 24'hAABBCC, 1'b0, s);
        total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", ifa.busy); end
        total++; if (cs_fall_at[0] != s + 1) begin bad++; $display("FAIL basic_cs_fall: got %0d want %0d", cs_fall_at[0] - s - 1, 0); end
        wait_done(0, b, 400);
        total++; if (done_cnt[0] != b + 1) begin bad++; $display("FAIL basic_done_cnt: got %0d want %0d", done_cnt[0] - b, 1); end
        total++; if (done_at[0] - s - 1 != 268) begin bad++; $display("FAIL basic_latency: got %0d want 268", done_at[0] - s - 1); end
        total++; if (first_rise_at[0] - s - 1 != 6) begin bad++; $display("FAIL basic_first_rise: got %0d want 6", first_rise_at[0] - s - 1); end
        total++; if (ifa.rd_data !== 24'hCCBBAA) begin bad++; $display("FAIL basic_data: got %h want ccbbaa", ifa.rd_data); end
        total++; if (ifa.last_addr_flag !== 1'b0) begin bad++; $display("FAIL basic_flag: got %b want 0", ifa.last_addr_flag); end
        total++; if (mosi_byte[0] !== 8'h85) begin bad++; $display("FAIL basic_cmd: got %h want 85", mosi_byte[0]); end
        total++; if (rise_cnt[0] != 32) begin bad++; $display("FAIL basic_edges: got %0d want 32", rise_cnt[0]); end
        total++; if (ifa.busy !== 1'b0 || ifa.spi_cs !== 1'b1) begin bad++; $display("FAIL basic_end: got busy=%b cs=%b want busy=0 cs=1", ifa.busy, ifa.spi_cs); end
        @(negedge clk); #1;
        total++; if (ifa.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", ifa.done); end
    endtask

    task automatic test_last_addr;
        int s, b;
        b = done_cnt[0];
        start_frame(0, 6'h3F, 24'h123456, 1'b0, s);
        wait_done(0, b, 400);
        total++; if (done_cnt[0] != b + 1) begin bad++; $display("FAIL last_done_cnt: got %0d want 1", done_cnt[0] - b); end
        total++; if (ifa.rd_data !== 24'h563412) begin bad++; $display("FAIL last_data: got %h want 563412", ifa.rd_data); end
        total++; if (ifa.last_addr_flag !== 1'b1) begin bad++; $display("FAIL last_flag: got %b want 1", ifa.last_addr_flag); end
        total++; if (mosi_byte[0] !== 8'hBF) begin bad++; $display("FAIL last_cmd: got %h want bf", mosi_byte[0]); end
    endtask

    task automatic test_busy_reject;
        int s, b, cf;
        b  = done_cnt[0];
        cf = cs_fall_cnt[0];
        start_frame(0, 6'h0A, 24'h010203, 1'b0, s);
        total++; if (ifa.last_addr_flag !== 1'b0) begin bad++; $display("FAIL rej_flag_clr: got %b want 0", ifa.last_addr_flag); end
        while (ncyc < s + 50) begin @(negedge clk); #1; end
        drive_start(0, 1'b1, 6'h3F);
        @(negedge clk); #1;
        drive_start(0, 1'b0, 6'h3F);
        while (ncyc < s + 200) begin @(negedge clk); #1; end
        drive_start(0, 1'b1, 6'h2C);
        @(negedge clk); #1;
        drive_start(0, 1'b0, 6'h2C);
        wait_done(0, b, 400);
        total++; if (done_at[0] - s - 1 != 268) begin bad++; $display("FAIL rej_latency: got %0d want 268", done_at[0] - s - 1); end
        total++; if (ifa.rd_data !== 24'h030201) begin bad++; $display("FAIL rej_data: got %h want 030201", ifa.rd_data); end
        total++; if (ifa.last_addr_flag !== 1'b0) begin bad++; $display("FAIL rej_flag: got %b want 0", ifa.last_addr_flag); end
        total++; if (mosi_byte[0] !== 8'h8A) begin bad++; $display("FAIL rej_cmd: got %h want 8a", mosi_byte[0]); end
        repeat (20) @(negedge clk);
        #1;
        total++; if (done_cnt[0] != b + 1) begin bad++; $display("FAIL rej_done_cnt: got %0d want 1", done_cnt[0] - b); end
        total++; if (cs_fall_cnt[0] != cf + 1) begin bad++; $display("FAIL rej_frames: got %0d want 1", cs_fall_cnt[0] - cf); end
    endtask

    task automatic test_reset_mid;
        int s, b;
        start_frame(0, 6'h01, 24'hF0F0F0, 1'b0, s);
        for (int k = 0; k < 400 && rise_cnt[0] < 12; k++) begin @(negedge clk); #1; end
        b = done_cnt[0];
        reset_n = 1'b0;
        #1;
        total++; if (ifa.spi_cs !== 1'b1) begin bad++; $display("FAIL mid_cs: got %b want 1", ifa.spi_cs); end
        total++; if (ifa.spi_clk !== 1'b0) begin bad++; $display("FAIL mid_sclk: got %b want 0", ifa.spi_clk); end
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", ifa.busy); end
        total++; if (ifa.rd_data !== 24'h0) begin bad++; $display("FAIL mid_data: got %h want 000000", ifa.rd_data); end
        @(negedge clk); #1;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        total++; if (ifa.spi_cs !== 1'b1 || done_cnt[0] != b) begin bad++; $display("FAIL mid_idle: got cs=%b dones=%0d want cs=1 dones=0", ifa.spi_cs, done_cnt[0] - b); end
        start_frame(0, 6'h07, 24'h112233, 1'b0, s);
        wait_done(0, b, 400);
        total++; if (done_at[0] - s - 1 != 268) begin bad++; $display("FAIL mid_latency: got %0d want 268", done_at[0] - s - 1); end
        total++; if (rise_cnt[0] != 32) begin bad++; $display("FAIL mid_edges: got %0d want 32", rise_cnt[0]); end
        total++; if (ifa.rd_data !== 24'h332211) begin bad++; $display("FAIL mid_rdata: got %h want 332211", ifa.rd_data); end
    endtask

    task automatic test_back_to_back;
        int s, b, d1;
        b = done_cnt[0];
        start_frame(0, 6'h11, 24'hDEADBE, 1'b1, s);
        wait_done(0, b, 400);
        d1 = done_at[0];
        total++; if (ifa.rd_data !== 24'hBEADDE) begin bad++; $display("FAIL b2b_data1: got %h want beadde", ifa.rd_data); end
        total++; if (ifa.spi_cs !== 1'b1) begin bad++; $display("FAIL b2b_cs_gap: got %b want 1", ifa.spi_cs); end
        total++; if (mosi_byte[0] !== 8'h91) begin bad++; $display("FAIL b2b_cmd1: got %h want 91", mosi_byte[0]); end
        slave_data[0] = 24'h5AC30F;
        drive_start(0, 1'b1, 6'h22);
        @(negedge clk); #1;
        drive_start(0, 1'b0, 6'h22);
        total++; if (cs_fall_at[0] != d1 + 1) begin bad++; $display("FAIL b2b_cs_fall: got %0d want 1", cs_fall_at[0] - d1); end
        total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", ifa.busy); end
        wait_done(0, b + 1, 400);
        total++; if (done_at[0] - d1 - 1 != 268) begin bad++; $display("FAIL b2b_latency: got %0d want 268", done_at[0] - d1 - 1); end
        total++; if (ifa.rd_data !== 24'h0FC35A) begin bad++; $display("FAIL b2b_data2: got %h want 0fc35a", ifa.rd_data); end
        total++; if (mosi_byte[0] !== 8'hA2) begin bad++; $display("FAIL b2b_cmd2: got %h want a2", mosi_byte[0]); end
    endtask

    task automatic test_fast_clk;
        int s, b;
        b = done_cnt[1];
        start_frame(1, 6'h2A, 24'h817EC3, 1'b0, s);
        wait_done(1, b, 200);
        total++; if (done_cnt[1] != b + 1) begin bad++; $display("FAIL fast_done_cnt: got %0d want 1", done_cnt[1] - b); end
        total++; if (done_at[1] - s - 1 != 69) begin bad++; $display("FAIL fast_latency: got %0d want 69", done_at[1] - s - 1); end
        total++; if (first_rise_at[1] - s - 1 != 3) begin bad++; $display("FAIL fast_first_rise: got %0d want 3", first_rise_at[1] - s - 1); end
        total++; if (rise_cnt[1] != 32) begin bad++; $display("FAIL fast_edges: got %0d want 32", rise_cnt[1]); end
        total++; if (mosi_byte[1] !== 8'hAA) begin bad++; $display("FAIL fast_cmd: got %h want aa", mosi_byte[1]); end
        total++; if (ifb.rd_data !== 24'hC37E81) begin bad++; $display("FAIL fast_data: got %h want c37e81", ifb.rd_data); end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_last_addr();
        test_busy_reject();
        test_reset_mid();
        test_back_to_back();
        test_fast_clk();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
